// File: rtl/ahb_ble_pkg.sv
// Shared AHB encodings and the address/control bundle used by the BLE input stage.
package ahb_ble_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } ahb_ctrl_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never request.
    function automatic logic trans_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_input_stage_ble.sv
// AHB input stage: passes a master's address phase straight through when granted,
// otherwise holds it and stalls the master until the output stage takes it.
module ahb_input_stage_ble
    import ahb_ble_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic        HMASTLOCKS,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic [3:0]  HMASTERS,
    input  logic        HREADYS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    output logic        sel_ip,
    output logic [31:0] addr_ip,
    output logic [1:0]  trans_ip,
    output logic        write_ip,
    output logic [2:0]  size_ip,
    output logic [2:0]  burst_ip,
    output logic [3:0]  prot_ip,
    output logic [3:0]  master_ip,
    output logic        mastlock_ip,
    output logic        held_tran_ip,
    input  logic        active_ip,
    input  logic        readyout_ip,
    input  logic        resp_ip
);

    ahb_ctrl_t live_ctrl;
    ahb_ctrl_t hold_ctrl;
    ahb_ctrl_t out_ctrl;
    logic      pend;
    logic      dphase;
    logic      trans_req;
    logic      grant_rdy;
    logic      accept;

    assign live_ctrl = '{sel:      HSELS,
                         addr:     HADDRS,
                         trans:    HTRANSS,
                         write:    HWRITES,
                         size:     HSIZES,
                         burst:    HBURSTS,
                         prot:     HPROTS,
                         master:   HMASTERS,
                         mastlock: HMASTLOCKS};

    assign trans_req    = HSELS & trans_is_active(HTRANSS) & HREADYS;
    assign grant_rdy    = active_ip & readyout_ip;
    assign held_tran_ip = pend | (HSELS & trans_is_active(HTRANSS));
    assign accept       = grant_rdy & held_tran_ip;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend      <= 1'b0;
            dphase    <= 1'b0;
            // NOTE: the holding register is cleared too so a reset never leaves stale control visible.
            hold_ctrl <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every flop sees pre-edge values of the others.
            if (trans_req)
                hold_ctrl <= live_ctrl;
            pend   <= pend ? ~grant_rdy : (trans_req & ~grant_rdy);
            // An accept coinciding with data-phase completion keeps dphase high: no bubble.
            dphase <= accept ? 1'b1 : (readyout_ip ? 1'b0 : dphase);
        end
    end

    assign out_ctrl = pend ? hold_ctrl : live_ctrl;

    assign sel_ip      = out_ctrl.sel;
    assign addr_ip     = out_ctrl.addr;
    assign trans_ip    = out_ctrl.trans;
    assign write_ip    = out_ctrl.write;
    assign size_ip     = out_ctrl.size;
    assign burst_ip    = out_ctrl.burst;
    assign prot_ip     = out_ctrl.prot;
    assign master_ip   = out_ctrl.master;
    assign mastlock_ip = out_ctrl.mastlock;

    assign HREADYOUTS = pend ? 1'b0 : (dphase ? readyout_ip : 1'b1);
    assign HRESPS     = dphase ? resp_ip : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_input_stage_ble.sv
// Directed bench for ahb_input_stage_ble: pass-through, hold, waits, error, back-to-back, reset.
module tb_ahb_input_stage_ble;
    import ahb_ble_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic        HMASTLOCKS;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_ip;
    logic [31:0] addr_ip;
    logic [1:0]  trans_ip;
    logic        write_ip;
    logic [2:0]  size_ip;
    logic [2:0]  burst_ip;
    logic [3:0]  prot_ip;
    logic [3:0]  master_ip;
    logic        mastlock_ip;
    logic        held_tran_ip;
    logic        active_ip;
    logic        readyout_ip;
    logic        resp_ip;

    int checks   = 0;
    int failures = 0;

    ahb_input_stage_ble dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HMASTLOCKS(HMASTLOCKS),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_ip(sel_ip), .addr_ip(addr_ip),
        .trans_ip(trans_ip), .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
        .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
        .held_tran_ip(held_tran_ip), .active_ip(active_ip), .readyout_ip(readyout_ip),
        .resp_ip(resp_ip)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then leave a settle window before new inputs are applied.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic hready, input logic act, input logic rdy, input logic rsp);
        HSELS       = sel;
        HTRANSS     = trans;
        HADDRS      = addr;
        HREADYS     = hready;
        active_ip   = act;
        readyout_ip = rdy;
        resp_ip     = rsp;
        #1;
    endtask

    initial begin
        HRESET = 1'b1; HWRITES = 1'b0; HSIZES = 3'd2; HMASTLOCKS = 1'b0;
        HBURSTS = 3'd0; HPROTS = 4'h3; HMASTERS = 4'h1;
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        HRESET = 1'b0;

        // Out of reset: idle, all outputs follow the live inputs.
        drive(1'b0, HTRANS_IDLE, 32'hDEAD_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_hreadyout", HREADYOUTS, 1);
        check("rst_hresp", HRESPS, 0);
        check("rst_held_tran", held_tran_ip, 0);
        check("rst_pend", dut.pend, 0);
        check("rst_dphase", dut.dphase, 0);
        check("rst_addr_live", addr_ip, 32'hDEAD_0000);
        check("rst_master_live", master_ip, 4'h1);

        // BUSY never requests nor sets pend.
        drive(1'b1, HTRANS_BUSY, 32'h0000_0800, 1'b1, 1'b0, 1'b1, 1'b0);
        check("busy_held_tran", held_tran_ip, 0);
        tick();
        check("busy_no_pend", dut.pend, 0);

        // Granted pass-through.
        HWRITES = 1'b1;
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b0);
        check("pt_addr", addr_ip, 32'h0000_1000);
        check("pt_write", write_ip, 1);
        check("pt_held_tran", held_tran_ip, 1);
        check("pt_hreadyout", HREADYOUTS, 1);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("pt_pend", dut.pend, 0);
        check("pt_dphase", dut.dphase, 1);
        check("pt_dp_hreadyout", HREADYOUTS, 1);
        tick();
        check("pt_dphase_done", dut.dphase, 0);

        // Ungranted hold: master bus pins change but the held transfer must stick.
        HWRITES = 1'b0; HMASTERS = 4'h5; HPROTS = 4'hA;
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("hold_req_hreadyout", HREADYOUTS, 1);
        check("hold_req_held_tran", held_tran_ip, 1);
        tick();
        HMASTERS = 4'h9; HPROTS = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, HTRANS_IDLE, 32'h0000_BAD0, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("hold_hreadyout_%0d", i), HREADYOUTS, 0);
            check($sformatf("hold_addr_%0d", i), addr_ip, 32'h0000_2000);
            check($sformatf("hold_held_tran_%0d", i), held_tran_ip, 1);
            tick();
        end
        drive(1'b0, HTRANS_IDLE, 32'h0000_BAD0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("grant_hreadyout", HREADYOUTS, 0);
        check("grant_addr", addr_ip, 32'h0000_2000);
        check("grant_master", master_ip, 4'h5);
        check("grant_prot", prot_ip, 4'hA);
        check("grant_trans", trans_ip, HTRANS_NONSEQ);
        tick();
        check("grant_pend_clear", dut.pend, 0);
        check("grant_dphase", dut.dphase, 1);

        // Data-phase wait: two low cycles then ready.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("wait_hreadyout_%0d", i), HREADYOUTS, 0);
            tick();
        end
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("wait_done_hreadyout", HREADYOUTS, 1);
        tick();
        check("wait_dphase_clear", dut.dphase, 0);

        // Two-cycle ERROR response passes through.
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_4000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("err1_hresp", HRESPS, HRESP_ERROR);
        check("err1_hreadyout", HREADYOUTS, 0);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("err2_hresp", HRESPS, HRESP_ERROR);
        check("err2_hreadyout", HREADYOUTS, 1);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("err_masked_no_dphase", HRESPS, HRESP_OKAY);

        // Back-to-back SEQ beats under continuous grant.
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_3000, 1'b1, 1'b1, 1'b1, 1'b0);
        check("b2b0_addr", addr_ip, 32'h0000_3000);
        check("b2b0_hreadyout", HREADYOUTS, 1);
        tick();
        drive(1'b1, HTRANS_SEQ, 32'h0000_3004, 1'b1, 1'b1, 1'b1, 1'b0);
        check("b2b1_addr", addr_ip, 32'h0000_3004);
        check("b2b1_trans", trans_ip, HTRANS_SEQ);
        check("b2b1_hreadyout", HREADYOUTS, 1);
        check("b2b1_pend", dut.pend, 0);
        check("b2b1_dphase", dut.dphase, 1);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("b2b2_dphase_kept", dut.dphase, 1);
        check("b2b2_pend", dut.pend, 0);
        check("b2b2_hreadyout", HREADYOUTS, 1);
        tick();

        // Reset while a transfer is pending.
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("prerst_pend", dut.pend, 1);
        check("prerst_hreadyout", HREADYOUTS, 0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        drive(1'b0, HTRANS_IDLE, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 1'b0);
        check("postrst_pend", dut.pend, 0);
        check("postrst_held_tran", held_tran_ip, 0);
        check("postrst_hreadyout", HREADYOUTS, 1);
        check("postrst_addr_live", addr_ip, 32'h0000_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_input_stage_ble.md
AHB_INPUT_STAGE_BLE -- requirements
Module: ahb_input_stage_ble

Interface
REQ-001 SHALL clock: HCLK  in  1  AHB clock, all state on rising edge.
REQ-002 SHALL reset: HRESET  in  1  reset, synchronous and active-high.
REQ-003 SHALL HSELS  in  1  master-side slave select.
REQ-004 SHALL HADDRS  in  32  address.
REQ-005 SHALL HTRANSS  in  2  transfer type; values IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL HWRITES / HSIZES / HMASTLOCKS  in  1/3/1  direction, size, lock.
REQ-007 SHALL HBURSTS / HPROTS / HMASTERS  in  3/4/4  burst, protection, master ID.
REQ-008 SHALL HREADYS  in  1  bus HREADY (address-phase qualifier).
REQ-009 SHALL HREADYOUTS  out  1  ready returned to the master.
REQ-010 SHALL HRESPS  out  1  response returned to the master (0=OKAY, 1=ERROR).
REQ-011 SHALL sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  out  same widths as the S inputs  address/control to the output stage.
REQ-012 SHALL held_tran_ip  out  1  transfer request to the output stage.
REQ-013 SHALL active_ip  in  1  the output stage has granted this port.
REQ-014 SHALL readyout_ip  in  1  the output stage ready (HREADYMUXM).
REQ-015 SHALL resp_ip  in  1  the output stage response.

Function
REQ-016 SHALL define trans_req = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ accepted from the master).
REQ-017 SHALL define accept = active_ip & readyout_ip & held_tran_ip.
REQ-018 SHALL capture all nine address/control inputs into a holding register on every trans_req cycle, and hold them otherwise.
REQ-019 SHALL keep a pend flag: next pend = pend ? ~(active_ip & readyout_ip) : (trans_req & ~(active_ip & readyout_ip)).
REQ-020 SHALL drive the *_ip outputs from the holding register when pend=1, and from live S inputs when pend=0 (zero-latency pass-through).
REQ-021 SHALL assert held_tran_ip = pend | (HSELS & HTRANSS[1]); IDLE/BUSY SHALL never raise a request.
REQ-022 SHALL keep a dphase flag: next dphase = accept ? 1 : (readyout_ip ? 0 : dphase).
REQ-023 SHALL drive HREADYOUTS = pend ? 0 : (dphase ? readyout_ip : 1).
REQ-024 SHALL drive HRESPS = dphase ? resp_ip : 0, so a two-cycle ERROR from the output stage passes through cycle-for-cycle.
REQ-025 SHALL, on a simultaneous dphase completion and new accept, keep dphase=1 (back-to-back pipelined transfers with no bubble).
REQ-026 SHALL, on trans_req while pend=0 with active_ip & readyout_ip, not set pend (direct launch).
REQ-027 SHALL ignore HSELS/HTRANSS changes while pend=1; the held transfer is never overwritten because HREADYS is low.

Reset
REQ-028 SHALL, while HRESET=1 at a clock edge, clear pend, dphase and the holding register to 0.
REQ-029 SHALL, out of reset, drive HREADYOUTS=1, HRESPS=0, held_tran_ip=0, and all *_ip outputs from the live inputs.
REQ-030 SHALL, when reset is asserted mid-pend or mid-dphase, discard the transfer with no residual request on the next cycle.

Structure
REQ-031 SHALL take the HTRANS and HRESP encodings from the shared package ahb_ble_pkg.
REQ-032 SHALL be flat, with no sub-module; the holding register and flags are local.

Verification
REQ-033 SHALL cover granted pass-through: NONSEQ to 0x0000_1000 with active_ip=1 and readyout_ip=1 -> addr_ip=0x1000 in the same cycle, pend stays 0, HREADYOUTS=1, then dphase=1.
REQ-034 SHALL cover an ungranted hold: NONSEQ to 0x2000 with active_ip=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles with addr_ip=0x2000 held; on the grant cycle pend clears and dphase=1.
REQ-035 SHALL cover data-phase wait: dphase=1 with readyout_ip=0 for 2 cycles -> HREADYOUTS=0 for 2 cycles, then 1.
REQ-036 SHALL cover error: resp_ip=1 for 2 cycles (readyout_ip 0 then 1) during dphase -> HRESPS=1 for both cycles, with HREADYOUTS 0 then 1.
REQ-037 SHALL cover back-to-back: SEQ beats at 0x3000 and 0x3004 with a continuous grant -> both launch with no pend and HREADYOUTS stays 1.
REQ-038 SHALL cover reset while pend=1 -> next cycle pend=0, held_tran_ip=0 and HREADYOUTS=1.
